// File: rtl/dlfloat_operand_loader.sv
// rtl/dlfloat_operand_loader.sv - byte-to-operand-pair assembler with FWFT pair FIFO for the DLFloat16 MAC
// Optional per-entry special flags on op_special: define DLF_LOADER_SPECIAL_EN.
module dlfloat_operand_loader #(
    parameter int DEPTH          = 4,
    parameter bit BYTE_LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [15:0]              op_a,
    output logic [15:0]              op_b,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [$clog2(DEPTH):0]   count,
`ifdef DLF_LOADER_SPECIAL_EN
    output logic [1:0]               op_special,
`endif
    output logic [7:0]               pair_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_A0, S_A1, S_B0, S_B1} state_e;

    state_e          state_q, state_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      pair_cnt_q;

    logic [15:0]     mem_a [DEPTH];
    logic [15:0]     mem_b [DEPTH];
`ifdef DLF_LOADER_SPECIAL_EN
    logic [1:0]      mem_sp [DEPTH];
    logic [1:0]      sp_push;
`endif

    logic            accept, push, pop;
    logic [15:0]     b_full;

    // Places a byte into the half of the operand selected by its position and the byte order.
    function automatic logic [15:0] put_byte(input logic [15:0] w, input logic [7:0] byt,
                                             input logic first);
        logic [15:0] r;
        r = w;
        if (first == BYTE_LSB_FIRST) r[7:0]  = byt;
        else                          r[15:8] = byt;
        return r;
    endfunction

    assign in_ready = (state_q != S_B1) || (count_q != FULL);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (state_q == S_B1);
    assign op_valid = (count_q != '0);
    assign pop      = op_valid && op_ready;
    assign b_full   = put_byte(b_q, in_byte, 1'b0);

    assign op_a     = op_valid ? mem_a[rd_ptr_q] : 16'h0000;
    assign op_b     = op_valid ? mem_b[rd_ptr_q] : 16'h0000;
    assign count    = count_q;
    assign pair_cnt = pair_cnt_q;

`ifdef DLF_LOADER_SPECIAL_EN
    assign sp_push    = {(a_q == 16'hFFFF) || (b_full == 16'hFFFF),
                         (a_q == 16'h0000) || (b_full == 16'h0000)};
    assign op_special = op_valid ? mem_sp[rd_ptr_q] : 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (accept) begin
            unique case (state_q)
                S_A0: begin a_d = put_byte(a_q, in_byte, 1'b1); state_d = S_A1; end
                S_A1: begin a_d = put_byte(a_q, in_byte, 1'b0); state_d = S_B0; end
                S_B0: begin b_d = put_byte(b_q, in_byte, 1'b1); state_d = S_B1; end
                S_B1: begin state_d = S_A0; end
                default: state_d = S_A0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A0;
            a_q        <= '0;
            b_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pair_cnt_q <= '0;
        end else if (flush) begin
            state_q    <= S_A0;
            a_q        <= '0;
            b_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pair_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                pair_cnt_q <= pair_cnt_q + 8'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: reads are gated by count, which is reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_a[wr_ptr_q]  <= a_q;
            mem_b[wr_ptr_q]  <= b_full;
`ifdef DLF_LOADER_SPECIAL_EN
            mem_sp[wr_ptr_q] <= sp_push;
`endif
        end
    end

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// tb/tb_dlfloat_operand_loader.sv - directed self-checking bench for dlfloat_operand_loader
module tb_dlfloat_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  count;
    logic [7:0]  pair_cnt;
`ifdef DLF_LOADER_SPECIAL_EN
    logic [1:0]  op_special;
`endif

    int checks   = 0;
    int failures = 0;

    dlfloat_operand_loader #(.DEPTH(4), .BYTE_LSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .count      (count),
`ifdef DLF_LOADER_SPECIAL_EN
        .op_special (op_special),
`endif
        .pair_cnt   (pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
    endtask

    task automatic check_head(input string tag, input logic [15:0] a, input logic [15:0] b);
        check({tag, "_valid"}, {31'd0, op_valid}, 32'd1);
        check({tag, "_a"}, {16'd0, op_a}, {16'd0, a});
        check({tag, "_b"}, {16'd0, op_b}, {16'd0, b});
    endtask

    logic [15:0] pa [5];
    logic [15:0] pb [5];

    initial begin
        pa[0] = 16'h1234; pb[0] = 16'h2345;
        pa[1] = 16'h5678; pb[1] = 16'h6789;
        pa[2] = 16'h9ABC; pb[2] = 16'hABCD;
        pa[3] = 16'hDEF0; pb[3] = 16'hEF01;
        pa[4] = 16'h0F1E; pb[4] = 16'h1E2D;

        rst_n = 1'b0; flush = 1'b0; in_byte = 8'h00; in_valid = 1'b0; op_ready = 1'b0;
        #23 rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_pair_cnt", {24'd0, pair_cnt}, 32'd0);
        check("rst_op_a", {16'd0, op_a}, 32'd0);
        check("rst_op_b", {16'd0, op_b}, 32'd0);
`ifdef DLF_LOADER_SPECIAL_EN
        check("rst_special", {30'd0, op_special}, 32'd0);
`endif

        // Single pair, one-edge latency then pop
        op_ready = 1'b1;
        send_byte(8'h00); send_byte(8'h3E); send_byte(8'h00); send_byte(8'h3F);
        check_head("t2_head", 16'h3E00, 16'h3F00);
        check("t2_pair_cnt", {24'd0, pair_cnt}, 32'd1);
        tick();
        check("t2_popped", {31'd0, op_valid}, 32'd0);
        check("t2_empty_a", {16'd0, op_a}, 32'd0);

        // Fill to full, stall on final byte only
        op_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_pair(pa[i], pb[i]);
        check("t3_full_count", {29'd0, count}, 32'd4);
        check("t3_full_ready_a0", {31'd0, in_ready}, 32'd1);
        send_byte(pa[4][7:0]); send_byte(pa[4][15:8]); send_byte(pb[4][7:0]);
        in_valid = 1'b1; in_byte = pb[4][15:8];
        @(negedge clk);
        check("t3_stall_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("t3_stall_count", {29'd0, count}, 32'd4);
        check_head("t3_hold", pa[0], pb[0]);
        op_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_indep", {31'd0, in_ready}, 32'd0);
        tick();
        op_ready = 1'b0;
        check("t3_after_pop", {29'd0, count}, 32'd3);
        check("t3_ready_again", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_refill", {29'd0, count}, 32'd4);
        op_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check_head($sformatf("t3_order%0d", i), pa[i], pb[i]);
            tick();
        end
        check("t3_drained", {31'd0, op_valid}, 32'd0);
        check("t3_pair_cnt", {24'd0, pair_cnt}, 32'd6);

        // Flush mid-pair, with a byte offered on the flush edge
        op_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_flush_cnt", {24'd0, pair_cnt}, 32'd0);
        check("t4_flush_count", {29'd0, count}, 32'd0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check_head("t4_head", 16'h2211, 16'h4433);
        check("t4_pair_cnt", {24'd0, pair_cnt}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Simultaneous push and pop at count=2
        send_pair(16'h0101, 16'h0202);
        send_pair(16'h0303, 16'h0404);
        check("t5_count2", {29'd0, count}, 32'd2);
        send_byte(8'h05); send_byte(8'h05); send_byte(8'h06);
        in_valid = 1'b1; in_byte = 8'h06; op_ready = 1'b1;
        tick();
        in_valid = 1'b0; op_ready = 1'b0;
        check("t5_count_same", {29'd0, count}, 32'd2);
        check_head("t5_head", 16'h0303, 16'h0404);
        op_ready = 1'b1;
        tick();
        check_head("t5_next", 16'h0505, 16'h0606);
        tick();
        check("t5_empty", {31'd0, op_valid}, 32'd0);
        check("t5_pair_cnt", {24'd0, pair_cnt}, 32'd3);

        // Special operand values
        op_ready = 1'b0;
        send_pair(16'hFFFF, 16'h3E00);
        send_pair(16'h0000, 16'hFFFF);
        check_head("t6_first", 16'hFFFF, 16'h3E00);
`ifdef DLF_LOADER_SPECIAL_EN
        check("t6_sp_first", {30'd0, op_special}, 32'd2);
`endif
        op_ready = 1'b1;
        tick();
        check_head("t6_second", 16'h0000, 16'hFFFF);
`ifdef DLF_LOADER_SPECIAL_EN
        check("t6_sp_second", {30'd0, op_special}, 32'd3);
`endif
        tick();
        check("t6_empty", {31'd0, op_valid}, 32'd0);
`ifdef DLF_LOADER_SPECIAL_EN
        check("t6_sp_empty", {30'd0, op_special}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
